// File: rtl/pwm_duty_ramp.sv
// Duty-value slew stage for the PWM generator: takes a target via valid/ready
// and walks value_o toward it by STEP once per PWM period, on the wrap edge.
module pwm_duty_ramp #(
  parameter int STEP   = 1,
  parameter int PERIOD = 512
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [8:0] target_i,
  input  logic       target_valid_i,
  output logic       target_ready_o,
  input  logic       abort_i,
  output logic [8:0] value_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       tick_o
);
  localparam int CW = $clog2(PERIOD);

  typedef enum logic {IDLE, RAMP} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [8:0]      value_q, value_d;
  logic [8:0]      tgt_q, tgt_d;
  logic            done_q, done_d;
  logic signed [9:0] diff;
  logic [9:0]      mag;
  logic            tick;

  assign tick  = (cnt_q == CW'(PERIOD - 1));
  assign cnt_d = tick ? '0 : cnt_q + 1'b1;

  // Nine-bit operands widened to ten so the difference keeps its sign.
  assign diff = $signed({1'b0, tgt_q}) - $signed({1'b0, value_q});
  assign mag  = diff[9] ? 10'(-diff) : 10'(diff);

  always_comb begin
    state_d = state_q;
    value_d = value_q;
    tgt_d   = tgt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (target_valid_i) begin
          tgt_d = target_i;
          if (target_i == value_q) done_d  = 1'b1;
          else                     state_d = RAMP;
        end
      end
      RAMP: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (tick) begin
          // Snap to target on the last step so the ramp never overshoots.
          if (mag <= 10'(STEP)) begin
            value_d = tgt_q;
            done_d  = 1'b1;
            state_d = IDLE;
          end else if (!diff[9]) begin
            value_d = value_q + 9'(STEP);
          end else begin
            value_d = value_q - 9'(STEP);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      value_q <= '0;
      tgt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      value_q <= value_d;
      tgt_q   <= tgt_d;
      done_q  <= done_d;
    end
  end

  assign target_ready_o = (state_q == IDLE);
  assign busy_o         = (state_q == RAMP);
  assign value_o        = value_q;
  assign done_o         = done_q;
  assign tick_o         = tick;
endmodule

// File: doc/pwm_duty_ramp.md
# pwm_duty_ramp

Upstream stage for the PWM generator: accepts a target duty value through a valid/ready handshake and slews its 9-bit `value` output toward it by a fixed step once per PWM period. Updates occur only at period boundaries, so the PWM comparator never sees a mid-period change. `value` connects directly to the PWM block's 9-bit `value` input, and both blocks are clocked by the same `clk`.

## Interface
- `STEP`, 1: duty increment/decrement applied per period, 1..511.
- `PERIOD`, 512: clocks per PWM period; must equal the PWM sawtooth length (2^9).
- `clk`  in  1  system clock, same clock as the PWM stage.
- `rst_n`  in  1  reset; one clock domain; asynchronous, active-low.
- `target`  in  9  requested duty, 0..511.
- `target_valid`  in  1  `target` is presented this cycle.
- `target_ready`  out  1  block can accept a target this cycle.
- `abort`  in  1  stop the ramp and hold the current `value`.
- `value`  out  9  current duty, fed to the PWM stage.
- `busy`  out  1  ramp in progress.
- `done`  out  1  one-cycle pulse when `value` reaches the target.
- `tick`  out  1  one-cycle pulse on the last clock of each period.

## Operation
- Reset (async, `rst_n`=0): `value`=0, period counter=0, state IDLE, `target_ready`=1, `busy`=0, `done`=0, `tick`=0, latched target=0.
- Period counter:
  - Width is ceil(log2(PERIOD)) bits.
  - Free-runs 0..PERIOD-1 and wraps, regardless of state.
  - `tick`=1 combinationally while counter==PERIOD-1.
- State IDLE:
  - `target_ready`=1, `busy`=0.
  - Accept on `target_valid`&`target_ready` at a rising edge, and latch `target`.
  - If the latched target equals `value`: stay IDLE and pulse `done` in the next cycle.
  - Otherwise go to RAMP.
- State RAMP:
  - `target_ready`=0, `busy`=1. `target_valid` is ignored.
  - On a clock with `tick`=1, compute diff = target − value in signed 10-bit arithmetic:
    - If |diff| ≤ STEP: `value`←target, `done`←1 for one cycle, go to IDLE.
    - Otherwise: `value`←value+STEP if diff>0, or value−STEP if diff<0.
  - `value` never wraps and always stays within 0..511.
- `abort`=1 in RAMP: go to IDLE at that edge. `value` is unchanged and `done` is not pulsed.
- `abort` has no effect in IDLE.
- `abort` and `tick` in the same cycle: abort wins and `value` is not stepped.
- `done` and a new acceptance: `done` is registered. A target accepted in the cycle `done` is high is legal and is handled normally.

## Timing
- Acceptance edge N: state=RAMP at N+1. The first step occurs at the first `tick` edge after N+1, which is at most PERIOD cycles later.
- `value` changes only on the clock edge where `tick`=1. The PWM sawtooth wraps to 0 on that same edge, so each period uses one duty value.
- Ramp duration is ceil(|target − start| / STEP) ticks.
- `done` goes high in the cycle after the final step edge, for exactly 1 cycle.
- `busy` falls on the same edge that `done` rises.
- Reset mid-ramp forces all outputs to their reset values immediately, and the counter restarts at 0.

## Test plan
- Reset: hold `rst_n`=0 with random inputs → `value`=0, `target_ready`=1, `busy`=0, `done`=0. Release → first `tick` at cycle 511.
- Ramp up, STEP=1: target=10 from 0 → `value` goes 1,2,…,10 on successive `tick` edges. `done` pulses once after the 10th tick, then `busy`=0 and `target_ready`=1.
- Ramp down, STEP=4: start 300, target=295 → 296 at the first tick, then 295 at the second tick. `done` pulses, with no undershoot below 295.
- Equal target: target=`value`=120 → no change to `value`, `busy` stays 0, `done` pulses the cycle after acceptance.
- Abort and ignored valid: ramp 0→200, present `target_valid`=1 with target=50 mid-ramp → ignored (`target_ready`=0). Assert `abort` on a `tick` cycle at value=7 → `value` stays 7, state IDLE, no `done`.
- Reset mid-ramp: ramp 0→511, drop `rst_n` at value=30 → `value`=0 and `busy`=0 asynchronously. After release, a new target=3 ramps correctly.
